mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//
// This block sits directly in front of an 8:1 selector8 tree. It uses the
// combinational mux as a timed parallel-to-serial path. On start it latches
// an 8-bit word onto the selector's data bus. It then steps the 3-bit select
// through all eight indices, holding each one for HOLD cycles. While it does
// this it samples the selector output x and rebuilds the word, so the
// rebuilt word can serve as a loopback check.
//
// Parameters
//   DIR   : 0 = select ascends 0->7, 1 = select descends 7->0
//   HOLD  : cycles each select value is held (1..16)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   load din and begin a scan (honoured only while idle)
//   din    in   [0:7] word to serialize; din[0] is selected by s=0
//   x      in   selector8 output
//   s      out  [2:0] registered select to selector8
//   a      out  [0:7] registered copy of din, stable for a whole scan
//   busy   out  high while scanning
//   done   out  one-cycle pulse when a scan completes
//   dout   out  [0:7] word rebuilt from sampled x (dout[i] = x while s=i)
//   err    out  set at completion when dout != a; held until next completion
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter bit          DIR  = 1'b0,
    parameter int unsigned HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [0:7] din,
    input  logic       x,
    output logic [2:0] s,
    output logic [0:7] a,
    output logic       busy,
    output logic       done,
    output logic [0:7] dout,
    output logic       err
);

    localparam logic [2:0] FIRST_IDX = DIR ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_IDX  = DIR ? 3'd0 : 3'd7;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [0:7] a_q, a_d;
    logic [3:0] hcnt_q, hcnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [0:7] dout_q, dout_d;
    logic       err_q, err_d;
    logic [0:7] dout_cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= 3'd0;
            a_q     <= 8'h00;
            hcnt_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            a_q     <= a_d;
            hcnt_q  <= hcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        a_d     = a_q;
        hcnt_d  = hcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;     // done is a single-cycle pulse
        dout_d  = dout_q;
        err_d   = err_q;

        // The rebuilt word including the bit being sampled this edge. It is
        // also used for the completion compare, so the last bit counts.
        dout_cap      = dout_q;
        dout_cap[s_q] = x;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = din;
                    s_d     = FIRST_IDX;
                    hcnt_d  = 4'd0;
                    busy_d  = 1'b1;
                    dout_d  = 8'h00;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (hcnt_q != HOLD_LAST) begin
                    hcnt_d = hcnt_q + 4'd1;
                end else begin
                    // x is sampled on the final hold cycle of the index, so a
                    // selector with a registered output still settles in time
                    // when HOLD >= 2.
                    hcnt_d = 4'd0;
                    dout_d = dout_cap;
                    if (s_q == LAST_IDX) begin
                        // s keeps the last index after completion.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = (dout_cap != a_q);
                    end else if (DIR) begin
                        s_d = s_q - 3'd1;
                    end else begin
                        s_d = s_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s    = s_q;
    assign a    = a_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    // Three configurations run side by side:
    // inst0 DIR=0 HOLD=1, inst1 DIR=0 HOLD=3, inst2 DIR=1 HOLD=1
    localparam int NI = 3;
    int P_DIR  [NI] = '{0, 0, 1};
    int P_HOLD [NI] = '{1, 3, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]       start_v = '0;
    logic [NI-1:0][0:7]  din_v   = '0;
    logic [NI-1:0]       fault_v = '0;
    logic [NI-1:0]       x_v;
    logic [NI-1:0][2:0]  s_v;
    logic [NI-1:0][0:7]  a_v;
    logic [NI-1:0]       busy_v, done_v, err_v;
    logic [NI-1:0][0:7]  dout_v;

    mux_scan_ctrl #(.DIR(1'b0), .HOLD(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .din(din_v[0]), .x(x_v[0]),
        .s(s_v[0]), .a(a_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .dout(dout_v[0]), .err(err_v[0]));
    mux_scan_ctrl #(.DIR(1'b0), .HOLD(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .din(din_v[1]), .x(x_v[1]),
        .s(s_v[1]), .a(a_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .dout(dout_v[1]), .err(err_v[1]));
    mux_scan_ctrl #(.DIR(1'b1), .HOLD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .din(din_v[2]), .x(x_v[2]),
        .s(s_v[2]), .a(a_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .dout(dout_v[2]), .err(err_v[2]));

    // Behavioural selector8, with an optional stuck-at-0 fault.
    always_comb begin
        for (int i = 0; i < NI; i++)
            x_v[i] = fault_v[i] ? 1'b0 : a_v[i][s_v[i]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A scan is counted in cycles: cycle c (1..8*HOLD) follows the start edge.
    // The index shown in cycle c is the ((c-1)/HOLD)-th entry of the scan
    // order. At the end of every HOLD-th cycle the selector's output for
    // that index is captured.
    logic       m_busy [NI] = '{default: 1'b0};
    int         m_c    [NI] = '{default: 0};
    logic [0:7] m_a    [NI] = '{default: 8'h00};
    logic [0:7] m_dout [NI] = '{default: 8'h00};
    logic       m_done [NI] = '{default: 1'b0};
    logic       m_err  [NI] = '{default: 1'b0};
    int         m_s    [NI] = '{default: 0};

    function automatic int ord(input int i, input int j);
        return (P_DIR[i] != 0) ? 7 - j : j;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    m_busy[i] = 1'b0; m_c[i] = 0; m_a[i] = 8'h00; m_dout[i] = 8'h00;
                    m_done[i] = 1'b0; m_err[i] = 1'b0; m_s[i] = 0;
                end else if (m_busy[i]) begin
                    if (m_c[i] % P_HOLD[i] == 0) begin
                        int idx;
                        idx = ord(i, m_c[i] / P_HOLD[i] - 1);
                        m_dout[i][idx] = fault_v[i] ? 1'b0 : m_a[i][idx];
                    end
                    if (m_c[i] == 8 * P_HOLD[i]) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_err[i]  = (m_dout[i] != m_a[i]);
                        m_s[i]    = ord(i, 7);
                    end else begin
                        m_c[i]++;
                    end
                end else begin
                    m_done[i] = 1'b0;
                    if (start_v[i]) begin
                        m_a[i] = din_v[i]; m_busy[i] = 1'b1; m_c[i] = 1; m_dout[i] = 8'h00;
                    end
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < NI; i++) begin
                    logic [2:0] es;
                    logic [19:0] got, exp;
                    es  = m_busy[i] ? 3'(ord(i, (m_c[i] - 1) / P_HOLD[i])) : 3'(m_s[i]);
                    got = {s_v[i], a_v[i], busy_v[i], done_v[i], dout_v[i], err_v[i]};
                    exp = {es, m_a[i], m_busy[i], m_done[i], m_dout[i], m_err[i]};
                    n_tests++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL cycle_cmp inst%0d t=%0t: got s=%0d a=%h busy=%b done=%b dout=%h err=%b, expected s=%0d a=%h busy=%b done=%b dout=%h err=%b",
                                 i, $time, s_v[i], a_v[i], busy_v[i], done_v[i], dout_v[i], err_v[i],
                                 es, m_a[i], m_busy[i], m_done[i], m_dout[i], m_err[i]);
                    end
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Returns at E0+2, i.e. inside cycle 1 of the new scan.
    task automatic pulse_start(input int i, input logic [7:0] d);
        @(posedge clk); #2;
        start_v[i] = 1'b1; din_v[i] = d;
        @(posedge clk); #2;
        start_v[i] = 1'b0;
    endtask

    // Count cycles until done is seen; c0 is the cycle we are currently in.
    task automatic wait_done(input int i, input int c0, input int exp_cyc, input string name);
        int c;
        c = c0;
        forever begin
            @(negedge clk);
            if (done_v[i]) break;
            c++;
            if (c > 200) break;
        end
        check(name, c, exp_cyc);
    endtask

    initial begin
        logic [7:0] rnd;
        int guard;

        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({s_v[0], a_v[0], busy_v[0], done_v[0], dout_v[0], err_v[0]}), 0);
        #3 rst_n = 1'b1;

        // 2. DIR=0 HOLD=1
        pulse_start(0, 8'b1011_0010);
        wait_done(0, 1, 9, "h1_done_cycle");
        check("h1_dout", int'(dout_v[0]), 8'hB2);
        check("h1_err", int'(err_v[0]), 0);

        // 3. HOLD=3
        pulse_start(1, 8'hA5);
        wait_done(1, 1, 25, "h3_done_cycle");
        check("h3_dout", int'(dout_v[1]), 8'hA5);

        // 4. DIR=1
        pulse_start(2, 8'h0F);
        wait_done(2, 1, 9, "dir1_done_cycle");
        check("dir1_dout", int'(dout_v[2]), 8'h0F);
        @(negedge clk);
        check("dir1_s_after", int'(s_v[2]), 0);

        // 5. fault, ignored start while busy, err recovery
        fault_v[0] = 1'b1;
        pulse_start(0, 8'hFF);
        repeat (3) @(posedge clk);
        #2 start_v[0] = 1'b1; din_v[0] = 8'h00;
        @(posedge clk); #2 start_v[0] = 1'b0;
        wait_done(0, 5, 9, "fault_done_cycle");
        check("fault_dout", int'(dout_v[0]), 8'h00);
        check("fault_err", int'(err_v[0]), 1);
        check("fault_a_kept", int'(a_v[0]), 8'hFF);
        fault_v[0] = 1'b0;
        pulse_start(0, 8'h3C);
        wait_done(0, 1, 9, "recover_done_cycle");
        check("recover_err", int'(err_v[0]), 0);

        // 6. reset mid-scan
        rnd = 8'($urandom);
        pulse_start(0, rnd);
        guard = 0;
        while (s_v[0] != 3'd4 && guard < 50) begin @(negedge clk); guard++; end
        check("reach_s4", int'(s_v[0]), 4);
        #1 rst_n = 1'b0;
        #1 check("midrst_outputs", int'({s_v[0], a_v[0], busy_v[0], done_v[0], dout_v[0], err_v[0]}), 0);
        repeat (2) @(negedge clk);
        check("midrst_no_done", int'(done_v[0]), 0);
        rst_n = 1'b1;
        pulse_start(0, 8'h81);
        wait_done(0, 1, 9, "post_rst_done_cycle");
        check("post_rst_dout", int'(dout_v[0]), 8'h81);

        // Randomized traffic: starts at arbitrary times (some while busy, some
        // in the done cycle), with random faults; the compare process checks it.
        repeat (800) begin
            @(posedge clk); #2;
            for (int i = 0; i < NI; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                din_v[i]   = 8'($urandom);
                fault_v[i] = ($urandom_range(0, 9) == 0);
            end
        end
        @(posedge clk); #2;
        start_v = '0;
        fault_v = '0;
        repeat (40) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
